reseed_scheduler: RTL and testbench

- Synthesizable, parametrised reseed controller for masked cores with a PRNG seed port (e.g. the 32-bit masked AES core).
- Generates seeds from an internal LFSR and offers them on a valid/ready seed channel. It does this once after start, then again after each observed execution start (random delay) or periodically (fixed delay), depending on MODE.
- Sits beside the masked core in on-chip test harnesses and FPGA KAT setups, where no host-driven reseed stimulus is available.

---
 rtl/reseed_if.sv | 11 +
 rtl/reseed_scheduler.sv | 109 ++++++++++
 tb/tb_reseed_scheduler.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reseed_if.sv
// Seed channel between the reseed scheduler (master) and a masked core's PRNG seed port (slave).
interface reseed_if #(
  parameter int SEED_W = 80
) ();
  logic              seed_valid;
  logic              seed_ready;
  logic [SEED_W-1:0] seed;

  modport master (output seed_valid, output seed, input seed_ready);
  modport slave  (input seed_valid, input seed, output seed_ready);
endinterface

// File: rtl/reseed_scheduler.sv
// Reseed controller: fills a seed from a 32-bit Galois LFSR and offers it on a valid/ready
// channel once after start, then after each exec_start (random delay) or periodically.
module reseed_scheduler #(
  parameter int          SEED_W    = 80,
  parameter int          MODE      = 1,
  parameter int          DLY_W     = 9,
  parameter int          PERIOD    = 256,
  parameter logic [31:0] LFSR_INIT = 32'h00000001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        exec_start,
  reseed_if.master    seed_ch,
  output logic        init_done,
  output logic        busy,
  output logic [15:0] reseed_count
);
  localparam int          NW    = (SEED_W + 31) / 32;
  localparam int          KW    = (NW > 1) ? $clog2(NW) : 1;
  localparam int          PW    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int          CNT_W = (DLY_W > PW) ? DLY_W : PW;
  localparam logic [31:0] POLY  = 32'h80200003;

  typedef enum logic [2:0] {IDLE, FILL, OFFER, WAIT_EXEC, COUNT} state_t;

  state_t           state, state_next;
  logic [31:0]      lfsr;
  logic [KW-1:0]    k;
  logic [CNT_W-1:0] cnt;
  logic             valid;
  logic             fill, last_word, handshake, load_dly, step;

  assign fill      = (state == FILL);
  assign last_word = (k == KW'(NW - 1));
  assign handshake = (state == OFFER) && valid && seed_ch.seed_ready;
  assign load_dly  = (state == WAIT_EXEC) && exec_start;
  assign step      = fill || load_dly;

  assign seed_ch.seed_valid = valid;
  assign busy               = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start) state_next = FILL;
      FILL:      if (last_word) state_next = OFFER;
      OFFER: begin
        if (handshake) begin
          if (MODE == 0)      state_next = IDLE;
          else if (MODE == 1) state_next = WAIT_EXEC;
          else                state_next = COUNT;
        end
      end
      WAIT_EXEC: if (exec_start) state_next = COUNT;
      COUNT:     if (cnt == '0) state_next = FILL;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lfsr         <= LFSR_INIT;
      k            <= '0;
      cnt          <= '0;
      valid        <= 1'b0;
      init_done    <= 1'b0;
      reseed_count <= '0;
    end else begin
      state <= state_next;
      if (step)
        lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'h0);
      if (fill)
        k <= last_word ? '0 : k + KW'(1);
      if (fill && last_word)
        valid <= 1'b1;
      else if (handshake)
        valid <= 1'b0;
      if (handshake) begin
        init_done <= 1'b1;
        if (reseed_count != 16'hFFFF)
          reseed_count <= reseed_count + 16'd1;
      end
      // Delay load and period reload share one down-counter; zero means "enter FILL next".
      if (load_dly)
        cnt <= CNT_W'(lfsr[DLY_W-1:0]);
      else if (handshake && MODE == 2)
        cnt <= CNT_W'(PERIOD - 1);
      else if (state == COUNT && cnt != '0)
        cnt <= cnt - CNT_W'(1);
    end
  end

  // One register per seed word; the top word keeps only the bits that reach SEED_W.
  for (genvar gi = 0; gi < NW; gi++) begin : g_word
    localparam int WB = ((SEED_W - 32 * gi) < 32) ? (SEED_W - 32 * gi) : 32;
    logic [WB-1:0] word;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        word <= '0;
      else if (fill && k == KW'(gi))
        word <= lfsr[WB-1:0];
    end

    assign seed_ch.seed[32*gi +: WB] = word;
  end
endmodule

// File: tb/tb_reseed_scheduler.sv
// Bench for reseed_scheduler: three instances (MODE 0/1/2) checked against a transaction-level LFSR model.
module tb_reseed_scheduler;
  localparam int SEED_W = 80;
  localparam int NW     = 3;
  localparam int DLY_W  = 9;
  localparam int PER    = 4;
  localparam logic [SEED_W-1:0] SEED0 = 80'h0002_80200003_00000001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic exec0 = 1'b0, exec1 = 1'b0, exec2 = 1'b0;
  logic init0, init1, init2, busy0, busy1, busy2;
  logic [15:0] cnt0, cnt1, cnt2;

  reseed_if #(.SEED_W(SEED_W)) if0 ();
  reseed_if #(.SEED_W(SEED_W)) if1 ();
  reseed_if #(.SEED_W(SEED_W)) if2 ();

  int total = 0;
  int bad   = 0;
  logic [31:0] m_lfsr0, m_lfsr1, m_lfsr2;
  int exp_cnt1 = 0;

  always #5 clk = ~clk;

  reseed_scheduler #(.SEED_W(SEED_W), .MODE(0), .DLY_W(DLY_W), .PERIOD(PER), .LFSR_INIT(32'h1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .exec_start(exec0), .seed_ch(if0.master),
    .init_done(init0), .busy(busy0), .reseed_count(cnt0));
  reseed_scheduler #(.SEED_W(SEED_W), .MODE(1), .DLY_W(DLY_W), .PERIOD(PER), .LFSR_INIT(32'h1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .exec_start(exec1), .seed_ch(if1.master),
    .init_done(init1), .busy(busy1), .reseed_count(cnt1));
  reseed_scheduler #(.SEED_W(SEED_W), .MODE(2), .DLY_W(DLY_W), .PERIOD(PER), .LFSR_INIT(32'h1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .exec_start(exec2), .seed_ch(if2.master),
    .init_done(init2), .busy(busy2), .reseed_count(cnt2));

  function automatic logic [31:0] lstep(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Next seed from a model LFSR: NW successive LFSR values, low word first, truncated.
  task automatic model_seed(inout logic [31:0] l, output logic [SEED_W-1:0] s);
    logic [32*NW-1:0] acc;
    for (int i = 0; i < NW; i++) begin
      acc[32*i +: 32] = l;
      l = lstep(l);
    end
    s = acc[SEED_W-1:0];
  endtask

  function automatic logic vld(input int w);
    case (w)
      0:       return if0.seed_valid;
      1:       return if1.seed_valid;
      default: return if2.seed_valid;
    endcase
  endfunction

  task automatic set_exec(input int w, input logic v);
    case (w)
      0:       exec0 = v;
      1:       exec1 = v;
      default: exec2 = v;
    endcase
  endtask

  task automatic pulse_start(input int w);
    case (w)
      0:       start0 = 1'b1;
      1:       start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
  endtask

  // Counts negedges until seed_valid; pulses exec_start once at step 'stray' (stray < 0: never).
  task automatic wait_valid(input int w, input int stray, output int n);
    n = 0;
    while (!vld(w) && n < 2000) begin
      if (n == stray) set_exec(w, 1'b1);
      @(negedge clk);
      set_exec(w, 1'b0);
      n++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if ({if0.seed_valid, if1.seed_valid, if2.seed_valid} !== 3'b000) begin
      bad++; $display("FAIL reset_valid got=%b want=000", {if0.seed_valid, if1.seed_valid, if2.seed_valid}); end
    total++; if ((if0.seed | if1.seed | if2.seed) !== '0) begin
      bad++; $display("FAIL reset_seed got=%h want=0", if0.seed | if1.seed | if2.seed); end
    total++; if ({init0, init1, init2} !== 3'b000) begin
      bad++; $display("FAIL reset_init got=%b want=000", {init0, init1, init2}); end
    total++; if ({busy0, busy1, busy2} !== 3'b000) begin
      bad++; $display("FAIL reset_busy got=%b want=000", {busy0, busy1, busy2}); end
    total++; if ((cnt0 | cnt1 | cnt2) !== 16'd0) begin
      bad++; $display("FAIL reset_count got=%h want=0", cnt0 | cnt1 | cnt2); end
    rst_n = 1'b1;
    m_lfsr0 = 32'h1; m_lfsr1 = 32'h1; m_lfsr2 = 32'h1;
    @(negedge clk);
  endtask

  task automatic test_first_seed();
    int n;
    logic [SEED_W-1:0] exp;
    pulse_start(1);
    total++; if (busy1 !== 1'b1 || if1.seed_valid !== 1'b0) begin
      bad++; $display("FAIL fill_entry busy=%b valid=%b want busy=1 valid=0", busy1, if1.seed_valid); end
    wait_valid(1, -1, n);
    total++; if (n != NW) begin
      bad++; $display("FAIL fill_latency got=%0d want=%0d", n, NW); end
    model_seed(m_lfsr1, exp);
    total++; if (if1.seed !== exp) begin
      bad++; $display("FAIL first_seed_model got=%h want=%h", if1.seed, exp); end
    total++; if (if1.seed !== SEED0) begin
      bad++; $display("FAIL first_seed_const got=%h want=%h", if1.seed, SEED0); end
  endtask

  task automatic test_backpressure();
    logic [SEED_W-1:0] held;
    held = if1.seed;
    if1.seed_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      total++; if (if1.seed_valid !== 1'b1 || if1.seed !== held) begin
        bad++; $display("FAIL backpressure cyc=%0d valid=%b seed=%h want valid=1 seed=%h",
                        i, if1.seed_valid, if1.seed, held); end
    end
    if1.seed_ready = 1'b1;
    @(negedge clk);
    if1.seed_ready = 1'b0;
    exp_cnt1 = 1;
    total++; if (if1.seed_valid !== 1'b0 || init1 !== 1'b1 || cnt1 !== 16'd1) begin
      bad++; $display("FAIL first_handshake valid=%b init=%b count=%0d want 0/1/1", if1.seed_valid, init1, cnt1); end
  endtask

  task automatic test_random_delay(input int iters);
    for (int it = 0; it < iters; it++) begin
      int gap, d, stray, n, hold;
      logic both;
      logic [SEED_W-1:0] exp;
      gap = (it == 0) ? 1 : int'($urandom_range(1, 6));
      repeat (gap) @(negedge clk);
      exec1 = 1'b1;
      @(negedge clk);
      exec1 = 1'b0;
      d = int'(m_lfsr1[DLY_W-1:0]);
      m_lfsr1 = lstep(m_lfsr1);
      stray = (it == 0) ? 0 : int'($urandom_range(0, d + NW));
      wait_valid(1, stray, n);
      total++; if (n != d + 1 + NW) begin
        bad++; $display("FAIL delay_latency it=%0d got=%0d want=%0d", it, n, d + 1 + NW); end
      model_seed(m_lfsr1, exp);
      total++; if (if1.seed !== exp) begin
        bad++; $display("FAIL delay_seed it=%0d got=%h want=%h", it, if1.seed, exp); end
      hold = int'($urandom_range(0, 4));
      repeat (hold) @(negedge clk);
      both = 1'($urandom_range(0, 1));
      if1.seed_ready = 1'b1;
      exec1 = both;
      @(negedge clk);
      if1.seed_ready = 1'b0;
      exec1 = 1'b0;
      exp_cnt1++;
      total++; if (if1.seed_valid !== 1'b0 || cnt1 !== 16'(exp_cnt1)) begin
        bad++; $display("FAIL delay_handshake it=%0d valid=%b count=%0d want 0/%0d", it, if1.seed_valid, cnt1, exp_cnt1); end
    end
  endtask

  task automatic test_period();
    int n;
    logic [SEED_W-1:0] exp;
    if2.seed_ready = 1'b1;
    pulse_start(2);
    wait_valid(2, -1, n);
    total++; if (n != NW) begin
      bad++; $display("FAIL period_first_latency got=%0d want=%0d", n, NW); end
    for (int i = 0; i < 5; i++) begin
      model_seed(m_lfsr2, exp);
      total++; if (if2.seed !== exp) begin
        bad++; $display("FAIL period_seed i=%0d got=%h want=%h", i, if2.seed, exp); end
      @(negedge clk);
      total++; if (if2.seed_valid !== 1'b0 || cnt2 !== 16'(i + 1)) begin
        bad++; $display("FAIL period_handshake i=%0d valid=%b count=%0d want 0/%0d", i, if2.seed_valid, cnt2, i + 1); end
      wait_valid(2, int'($urandom_range(0, PER + NW - 1)), n);
      total++; if (n != PER + NW) begin
        bad++; $display("FAIL period_spacing i=%0d got=%0d want=%0d", i, n, PER + NW); end
    end
    if2.seed_ready = 1'b0;
  endtask

  task automatic test_mode0();
    int n;
    logic quiet;
    logic [SEED_W-1:0] exp, first;
    pulse_start(0);
    wait_valid(0, -1, n);
    model_seed(m_lfsr0, exp);
    total++; if (n != NW || if0.seed !== exp) begin
      bad++; $display("FAIL mode0_seed1 lat=%0d seed=%h want lat=%0d seed=%h", n, if0.seed, NW, exp); end
    first = if0.seed;
    if0.seed_ready = 1'b1;
    @(negedge clk);
    if0.seed_ready = 1'b0;
    total++; if (busy0 !== 1'b0 || cnt0 !== 16'd1 || init0 !== 1'b1) begin
      bad++; $display("FAIL mode0_idle busy=%b count=%0d init=%b want 0/1/1", busy0, cnt0, init0); end
    quiet = 1'b1;
    for (int i = 0; i < 12; i++) begin
      exec0 = 1'(i & 1);
      @(negedge clk);
      if (if0.seed_valid !== 1'b0 || busy0 !== 1'b0) quiet = 1'b0;
    end
    exec0 = 1'b0;
    total++; if (quiet !== 1'b1) begin
      bad++; $display("FAIL mode0_no_reseed quiet=%b want=1", quiet); end
    pulse_start(0);
    wait_valid(0, -1, n);
    model_seed(m_lfsr0, exp);
    total++; if (n != NW || if0.seed !== exp) begin
      bad++; $display("FAIL mode0_seed2 lat=%0d seed=%h want lat=%0d seed=%h", n, if0.seed, NW, exp); end
    total++; if (if0.seed === first) begin
      bad++; $display("FAIL mode0_seed_differs got=%h equal to first=%h", if0.seed, first); end
  endtask

  task automatic test_reset_offer();
    int n;
    exec1 = 1'b1;
    @(negedge clk);
    exec1 = 1'b0;
    wait_valid(1, -1, n);
    total++; if (if1.seed_valid !== 1'b1) begin
      bad++; $display("FAIL offer_reached valid=%b want=1", if1.seed_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (if1.seed_valid !== 1'b0 || cnt1 !== 16'd0 || init1 !== 1'b0 || busy1 !== 1'b0 || if1.seed !== '0) begin
      bad++; $display("FAIL async_reset valid=%b count=%0d init=%b busy=%b seed=%h want all 0",
                      if1.seed_valid, cnt1, init1, busy1, if1.seed); end
    @(negedge clk);
    rst_n = 1'b1;
    m_lfsr1 = 32'h1;
    @(negedge clk);
    pulse_start(1);
    wait_valid(1, -1, n);
    total++; if (n != NW || if1.seed !== SEED0) begin
      bad++; $display("FAIL reseed_after_reset lat=%0d seed=%h want lat=%0d seed=%h", n, if1.seed, NW, SEED0); end
  endtask

  initial begin
    if0.seed_ready = 1'b0;
    if1.seed_ready = 1'b0;
    if2.seed_ready = 1'b0;
    test_reset();
    test_first_seed();
    test_backpressure();
    test_random_delay(8);
    test_period();
    test_mode0();
    test_reset_offer();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
